// File: rtl/fe_de_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fe_de_ctrl_pkg
// Description : Shared types and default constants for the fetch->decode
//               pipeline-register sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
package fe_de_ctrl_pkg;

    // Flush sequencer states
    typedef enum logic [0:0] {
        FEDE_ST_RUN   = 1'b0,
        FEDE_ST_FLUSH = 1'b1
    } fede_state_e;

    // Default configuration
    localparam int unsigned FEDE_FLUSH_BUBBLES = 1;
    localparam int unsigned FEDE_BTB_WARMUP    = 10;
    localparam int unsigned FEDE_STALL_CNT_W   = 16;

    // Both FLUSH_BUBBLES and BTB_WARMUP are bounded to 1..15
    localparam int unsigned FEDE_SEQ_CNT_W     = 4;

endpackage : fe_de_ctrl_pkg
`default_nettype wire

// File: rtl/fede_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : fede_sat_cnt
// Description : Parameterized saturating up-counter with synchronous clear.
//               Clear has priority over increment; the count holds at MAX.
// Ports       : clk_i  - clock
//               rst_i  - asynchronous active-high reset (count -> 0)
//               clr_i  - synchronous clear
//               inc_i  - increment request
//               cnt_o  - current count
// Revision    : 1.0 - initial release
// ============================================================================
module fede_sat_cnt #(
    parameter int unsigned   W   = 16,
    parameter logic [W-1:0]  MAX = '1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != MAX)) begin
            cnt_q <= cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign cnt_o = cnt_q;

endmodule : fede_sat_cnt
`default_nettype wire

// File: rtl/fe_de_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fe_de_pipe_ctrl
// Description : Sequencing controller for the fetch->decode pipeline register.
//               Merges stall / flush / cross-boundary events into prioritized
//               enables and clears (reset > flush > bubble > stall > load),
//               sequences single-entry BTB capture plus its post-reset
//               warm-up, and keeps a saturating stall-cycle counter.
// Config      : `define FEDE_EXC_FLUSH_EN to make writeback exceptions and
//               interrupts flush the fe/de register directly.
// Ports       : clk_i, cpurst_i (async, active-high)
//               de_stall_i, de_store_load_conflict_i, exe_store_load_conflict_i,
//               readram_stall_i, mem_stall_i, mult_stall_i, div_stall_i
//               fet_flush_i, branch_predict_err_i, mem2wb_exp_ffout_i,
//               interrupt_i, cross_bd_ff_i, de2fe_branch_i,
//               de2ex_inst_valid_i, stall_cnt_clr_i
//               fet_stall_o, fede_ctl_en_o, fede_instr_en_o, fede_flush_o,
//               fede_instr_bubble_o, btb_capture_o, btb_valid_o, stall_cnt_o
// Revision    : 1.0 - initial release
// ============================================================================
module fe_de_pipe_ctrl
    import fe_de_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_BUBBLES = FEDE_FLUSH_BUBBLES,
    parameter int unsigned BTB_WARMUP    = FEDE_BTB_WARMUP,
    parameter int unsigned STALL_CNT_W   = FEDE_STALL_CNT_W
) (
    input  logic                   clk_i,
    input  logic                   cpurst_i,
    input  logic                   de_stall_i,
    input  logic                   de_store_load_conflict_i,
    input  logic                   exe_store_load_conflict_i,
    input  logic                   readram_stall_i,
    input  logic                   mem_stall_i,
    input  logic                   mult_stall_i,
    input  logic                   div_stall_i,
    input  logic                   fet_flush_i,
    input  logic                   branch_predict_err_i,
    input  logic                   mem2wb_exp_ffout_i,
    input  logic                   interrupt_i,
    input  logic                   cross_bd_ff_i,
    input  logic                   de2fe_branch_i,
    input  logic                   de2ex_inst_valid_i,
    input  logic                   stall_cnt_clr_i,
    output logic                   fet_stall_o,
    output logic                   fede_ctl_en_o,
    output logic                   fede_instr_en_o,
    output logic                   fede_flush_o,
    output logic                   fede_instr_bubble_o,
    output logic                   btb_capture_o,
    output logic                   btb_valid_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned CW = FEDE_SEQ_CNT_W;

    // A single-bubble flush is fully covered by the combinational request
    localparam bit           C_MULTI_BUBBLE = (FLUSH_BUBBLES > 1);
    localparam logic [CW-1:0] C_FLUSH_RELOAD = CW'(FLUSH_BUBBLES - 1);
    localparam logic [CW-1:0] C_WARM_MAX     = CW'(BTB_WARMUP);
    localparam logic [CW-1:0] C_WARM_PRE     = CW'(BTB_WARMUP - 1);

    fede_state_e   state_q;
    logic [CW-1:0] flush_cnt_q;
    logic          btb_arm_q;
    logic          btb_valid_q;
    logic [CW-1:0] warm_cnt;
    logic          flush_req;
    logic          fet_stall;
    logic          fede_flush;
    logic          fede_ctl_en;
    logic          btb_capture;

    // ------------------------------------------------------------------
    // Flush request
    // ------------------------------------------------------------------
`ifdef FEDE_EXC_FLUSH_EN
    assign flush_req = fet_flush_i | branch_predict_err_i
                     | mem2wb_exp_ffout_i | interrupt_i;
`else
    // Traps are redirected through fet_flush; these inputs are not used here
    logic unused_exc_inputs;
    assign unused_exc_inputs = mem2wb_exp_ffout_i | interrupt_i;
    assign flush_req = fet_flush_i | branch_predict_err_i;
`endif

    // ------------------------------------------------------------------
    // Flush sequencer: holds fede_flush for the remaining bubble cycles.
    // A new request while flushing simply restarts the count.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge cpurst_i) begin
        if (cpurst_i) begin
            state_q     <= FEDE_ST_RUN;
            flush_cnt_q <= '0;
        end else begin
            case (state_q)
                FEDE_ST_RUN: begin
                    if (flush_req && C_MULTI_BUBBLE) begin
                        state_q     <= FEDE_ST_FLUSH;
                        flush_cnt_q <= C_FLUSH_RELOAD;
                    end
                end
                FEDE_ST_FLUSH: begin
                    if (flush_req) begin
                        flush_cnt_q <= C_FLUSH_RELOAD;
                    end else if (flush_cnt_q == CW'(1)) begin
                        state_q     <= FEDE_ST_RUN;
                        flush_cnt_q <= '0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q     <= FEDE_ST_RUN;
                    flush_cnt_q <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Enables and clears
    // ------------------------------------------------------------------
    assign fet_stall   = de_stall_i | de_store_load_conflict_i | exe_store_load_conflict_i
                       | readram_stall_i | mem_stall_i | mult_stall_i | div_stall_i;
    assign fede_flush  = flush_req | (state_q == FEDE_ST_FLUSH);
    assign fede_ctl_en = ~fede_flush & ~de_stall_i & ~de_store_load_conflict_i;

    assign fet_stall_o         = fet_stall;
    assign fede_flush_o        = fede_flush;
    assign fede_ctl_en_o       = fede_ctl_en;
    assign fede_instr_en_o     = fede_ctl_en & ~fet_stall;
    // Withheld under de_stall so the bubble lands once decode can accept it
    assign fede_instr_bubble_o = cross_bd_ff_i & ~de_stall_i & ~fede_flush;

    // ------------------------------------------------------------------
    // BTB capture: arm on a decoded branch, fire when that instr goes to
    // execute. Capture takes priority over a same-cycle re-arm.
    // ------------------------------------------------------------------
    assign btb_capture   = btb_arm_q & de2ex_inst_valid_i;
    assign btb_capture_o = btb_capture;

    always_ff @(posedge clk_i or posedge cpurst_i) begin
        if (cpurst_i) begin
            btb_arm_q <= 1'b0;
        end else if (btb_capture) begin
            btb_arm_q <= 1'b0;
        end else if (de2fe_branch_i) begin
            btb_arm_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // BTB warm-up: btb_valid is set on the edge where warm_cnt reaches
    // BTB_WARMUP, i.e. exactly BTB_WARMUP clocks after reset release.
    // ------------------------------------------------------------------
    fede_sat_cnt #(
        .W   (CW),
        .MAX (C_WARM_MAX)
    ) u_warm_cnt (
        .clk_i (clk_i),
        .rst_i (cpurst_i),
        .clr_i (1'b0),
        .inc_i (1'b1),
        .cnt_o (warm_cnt)
    );

    always_ff @(posedge clk_i or posedge cpurst_i) begin
        if (cpurst_i) begin
            btb_valid_q <= 1'b0;
        end else begin
            btb_valid_q <= btb_valid_q | (warm_cnt == C_WARM_PRE) | (warm_cnt == C_WARM_MAX);
        end
    end

    assign btb_valid_o = btb_valid_q;

    // ------------------------------------------------------------------
    // Stall-cycle performance counter
    // ------------------------------------------------------------------
    fede_sat_cnt #(
        .W   (STALL_CNT_W),
        .MAX ({STALL_CNT_W{1'b1}})
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (cpurst_i),
        .clr_i (stall_cnt_clr_i),
        .inc_i (fet_stall),
        .cnt_o (stall_cnt_o)
    );

endmodule : fe_de_pipe_ctrl
`default_nettype wire

// File: tb/tb_fe_de_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fe_de_pipe_ctrl
// Description : Directed self-checking bench for fe_de_pipe_ctrl built with
//               FLUSH_BUBBLES=3, BTB_WARMUP=10, STALL_CNT_W=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fe_de_pipe_ctrl;

    logic       clk = 1'b0;
    logic       cpurst;
    logic       de_stall, de_slc, exe_slc, readram_stall, mem_stall, mult_stall, div_stall;
    logic       fet_flush, bpe, mem2wb_exp, interrupt, cross_bd, de2fe_branch, de2ex_valid;
    logic       stall_cnt_clr;
    logic       fet_stall, ctl_en, instr_en, fede_flush, bubble, btb_capture, btb_valid;
    logic [3:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fe_de_pipe_ctrl #(
        .FLUSH_BUBBLES (3),
        .BTB_WARMUP    (10),
        .STALL_CNT_W   (4)
    ) dut (
        .clk_i                     (clk),
        .cpurst_i                  (cpurst),
        .de_stall_i                (de_stall),
        .de_store_load_conflict_i  (de_slc),
        .exe_store_load_conflict_i (exe_slc),
        .readram_stall_i           (readram_stall),
        .mem_stall_i               (mem_stall),
        .mult_stall_i              (mult_stall),
        .div_stall_i               (div_stall),
        .fet_flush_i               (fet_flush),
        .branch_predict_err_i      (bpe),
        .mem2wb_exp_ffout_i        (mem2wb_exp),
        .interrupt_i               (interrupt),
        .cross_bd_ff_i             (cross_bd),
        .de2fe_branch_i            (de2fe_branch),
        .de2ex_inst_valid_i        (de2ex_valid),
        .stall_cnt_clr_i           (stall_cnt_clr),
        .fet_stall_o               (fet_stall),
        .fede_ctl_en_o             (ctl_en),
        .fede_instr_en_o           (instr_en),
        .fede_flush_o              (fede_flush),
        .fede_instr_bubble_o       (bubble),
        .btb_capture_o             (btb_capture),
        .btb_valid_o               (btb_valid),
        .stall_cnt_o               (stall_cnt)
    );

    // Advance to 1 time unit after the next rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        de_stall = 0; de_slc = 0; exe_slc = 0; readram_stall = 0; mem_stall = 0;
        mult_stall = 0; div_stall = 0; fet_flush = 0; bpe = 0; mem2wb_exp = 0;
        interrupt = 0; cross_bd = 0; de2fe_branch = 0; de2ex_valid = 0; stall_cnt_clr = 0;
    endtask

    // Leaves the bench 1 unit into cycle 0 after reset release
    task automatic test_reset();
        clear_inputs();
        cpurst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (btb_valid !== 1'b0) begin errors++; $display("FAIL reset_btb_valid got=%b exp=0", btb_valid); end
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
        checks++; if (fede_flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", fede_flush); end
        checks++; if (ctl_en !== 1'b1 || instr_en !== 1'b1) begin errors++; $display("FAIL reset_enables got=%b%b exp=11", ctl_en, instr_en); end
        @(posedge clk);
        #1;
        cpurst = 1'b0;
    endtask

    task automatic test_warmup();
        for (int k = 0; k <= 12; k++) begin
            #3;
            checks++;
            if (btb_valid !== (k >= 10)) begin
                errors++; $display("FAIL warmup_cycle%0d got=%b exp=%b", k, btb_valid, (k >= 10));
            end
            next_cycle();
        end
    endtask

    task automatic test_flush();
        // Single request: flush cycles 0..2, clear at 3
        for (int c = 0; c <= 3; c++) begin
            fet_flush = (c == 0);
            #3;
            checks++; if (fede_flush !== (c < 3)) begin errors++; $display("FAIL flush1_c%0d got=%b exp=%b", c, fede_flush, (c < 3)); end
            checks++; if (ctl_en !== (c >= 3)) begin errors++; $display("FAIL flush1_ctl_c%0d got=%b exp=%b", c, ctl_en, (c >= 3)); end
            next_cycle();
        end
        // Re-request one cycle later extends the flush through cycle 3
        for (int c = 0; c <= 4; c++) begin
            fet_flush = (c == 0);
            bpe       = (c == 1);
            #3;
            checks++; if (fede_flush !== (c < 4)) begin errors++; $display("FAIL flush2_c%0d got=%b exp=%b", c, fede_flush, (c < 4)); end
            next_cycle();
        end
        bpe = 0;
    endtask

    task automatic test_stall_mix();
        logic [6:0] vec;
        for (int b = 0; b < 7; b++) begin
            vec = 7'b1 << b;
            {div_stall, mult_stall, mem_stall, readram_stall, exe_slc, de_slc, de_stall} = vec;
            #3;
            checks++; if (fet_stall !== 1'b1) begin errors++; $display("FAIL stall_or_bit%0d got=%b exp=1", b, fet_stall); end
            checks++; if (ctl_en !== (b >= 2)) begin errors++; $display("FAIL stall_ctl_bit%0d got=%b exp=%b", b, ctl_en, (b >= 2)); end
            checks++; if (instr_en !== 1'b0) begin errors++; $display("FAIL stall_instr_bit%0d got=%b exp=0", b, instr_en); end
            next_cycle();
        end
        clear_inputs();
        #3;
        checks++; if (fet_stall !== 1'b0 || instr_en !== 1'b1) begin errors++; $display("FAIL stall_idle got=%b%b exp=01", fet_stall, instr_en); end
        next_cycle();
    endtask

    task automatic test_cross_bd();
        for (int c = 0; c <= 2; c++) begin
            cross_bd = 1; de_stall = (c < 2);
            #3;
            checks++; if (bubble !== (c == 2)) begin errors++; $display("FAIL bubble_c%0d got=%b exp=%b", c, bubble, (c == 2)); end
            next_cycle();
        end
        // Flush outranks the bubble
        de_stall = 0; fet_flush = 1;
        #3;
        checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL bubble_vs_flush got=%b exp=0", bubble); end
        next_cycle();
        clear_inputs();
        repeat (3) next_cycle();
    endtask

    task automatic test_btb();
        // Branch at 0, valid at 2 and 3: capture only at 2
        for (int c = 0; c <= 3; c++) begin
            de2fe_branch = (c == 0); de2ex_valid = (c >= 2);
            #3;
            checks++; if (btb_capture !== (c == 2)) begin errors++; $display("FAIL btb_seq_c%0d got=%b exp=%b", c, btb_capture, (c == 2)); end
            next_cycle();
        end
        // Arm at 0; branch+valid together at 1 -> capture; valid at 2 -> none
        for (int c = 0; c <= 2; c++) begin
            de2fe_branch = (c <= 1); de2ex_valid = (c >= 1);
            #3;
            checks++; if (btb_capture !== (c == 1)) begin errors++; $display("FAIL btb_same_c%0d got=%b exp=%b", c, btb_capture, (c == 1)); end
            next_cycle();
        end
        // A flush between arm and valid leaves the arm intact
        clear_inputs();
        de2fe_branch = 1;
        next_cycle();
        de2fe_branch = 0; fet_flush = 1;
        next_cycle();
        fet_flush = 0; de2ex_valid = 1;
        #3;
        checks++; if (btb_capture !== 1'b1) begin errors++; $display("FAIL btb_after_flush got=%b exp=1", btb_capture); end
        next_cycle();
        clear_inputs();
        repeat (3) next_cycle();
    endtask

    task automatic test_stall_cnt();
        stall_cnt_clr = 1;
        next_cycle();
        stall_cnt_clr = 0;
        #3;
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL scnt_clr got=%0d exp=0", stall_cnt); end
        for (int i = 1; i <= 20; i++) begin
            mem_stall = 1;
            next_cycle();
            if (i == 5) begin
                #3;
                checks++; if (stall_cnt !== 4'd5) begin errors++; $display("FAIL scnt_5 got=%0d exp=5", stall_cnt); end
                #(-0);
            end
        end
        mem_stall = 0;
        #3;
        checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL scnt_sat got=%0d exp=15", stall_cnt); end
        next_cycle();
        // Clear wins over a simultaneous increment
        stall_cnt_clr = 1; mem_stall = 1;
        next_cycle();
        stall_cnt_clr = 0; mem_stall = 0;
        #3;
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL scnt_clr_wins got=%0d exp=0", stall_cnt); end
        next_cycle();
    endtask

    task automatic test_exc();
        logic exp_flush;
`ifdef FEDE_EXC_FLUSH_EN
        exp_flush = 1'b1;
`else
        exp_flush = 1'b0;
`endif
        interrupt = 1;
        #3;
        checks++; if (fede_flush !== exp_flush) begin errors++; $display("FAIL exc_interrupt got=%b exp=%b", fede_flush, exp_flush); end
        next_cycle();
        interrupt = 0;
        repeat (3) next_cycle();
        mem2wb_exp = 1;
        #3;
        checks++; if (fede_flush !== exp_flush) begin errors++; $display("FAIL exc_mem2wb got=%b exp=%b", fede_flush, exp_flush); end
        next_cycle();
        mem2wb_exp = 0;
        repeat (3) next_cycle();
    endtask

    task automatic test_reset_mid();
        fet_flush = 1; de2fe_branch = 1; mem_stall = 1;
        next_cycle();
        clear_inputs();
        #2;
        checks++; if (fede_flush !== 1'b1) begin errors++; $display("FAIL mid_in_flush got=%b exp=1", fede_flush); end
        cpurst = 1;
        #1;
        checks++; if (fede_flush !== 1'b0) begin errors++; $display("FAIL mid_async_flush got=%b exp=0", fede_flush); end
        checks++; if (stall_cnt !== 4'd0 || btb_valid !== 1'b0) begin errors++; $display("FAIL mid_async_regs got=%0d/%b exp=0/0", stall_cnt, btb_valid); end
        next_cycle();
        cpurst = 0;
        de2ex_valid = 1;
        #3;
        checks++; if (btb_capture !== 1'b0) begin errors++; $display("FAIL mid_arm_cleared got=%b exp=0", btb_capture); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_flush();
        test_stall_mix();
        test_cross_bd();
        test_btb();
        test_stall_cnt();
        test_exc();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute guard against a hung run
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_fe_de_pipe_ctrl
`default_nettype wire
